// File: rtl/instability_pkg.sv
// Shared definitions for the instability sweep block.
// Holds the sweep FSM state encoding, the default parameter values used by
// the top and the jump detector, and the width of the consecutive-jump counter.
package instability_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_EVAL   = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  localparam int WIDTH_DEF     = 10;
  localparam int DELTA_DEF     = 300;
  localparam int IREF_STEP_DEF = 50;
  localparam int IREF_MIN_DEF  = 0;
  localparam int CONFIRM_DEF   = 2;
  localparam int TIMEOUT_DEF   = 1023;

  // CONFIRM is limited to 1..7, so three bits hold the run of jumps.
  localparam int RUN_W = 3;

endpackage

// File: rtl/jump_detector.sv
// Classifies each new Q sample against the previous one.
// A jump is a positive sample-to-sample increase strictly larger than DELTA;
// decreases are never jumps. Counts consecutive jumps and flags when the run
// reaches CONFIRM.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - start of a new sweep, zeroes the run counter
//   eval      - one-cycle strobe: classify q against last_q this cycle
//   first     - q is the first sample of the sweep (never a jump)
//   q         - sample being evaluated
//   last_q    - previous sample of the sweep
//   jump      - q is a jump relative to last_q
//   hit       - this evaluation brings the run of jumps to CONFIRM
//   run_cnt   - current consecutive-jump count
module jump_detector
  import instability_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int DELTA   = DELTA_DEF,
  parameter int CONFIRM = CONFIRM_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             eval,
  input  logic             first,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] last_q,
  output logic             jump,
  output logic             hit,
  output logic [RUN_W-1:0] run_cnt
);

  localparam logic signed [WIDTH:0] DELTA_S   = (WIDTH+1)'(DELTA);
  localparam logic [RUN_W-1:0]      CONFIRM_W = RUN_W'(CONFIRM);

  logic signed [WIDTH:0] diff_s;
  logic [RUN_W-1:0]      run_next_s;

  // Signed difference with one guard bit so a drop stays negative.
  always_comb begin
    diff_s     = $signed({1'b0, q}) - $signed({1'b0, last_q});
    jump       = 1'b0;
    run_next_s = {RUN_W{1'b0}};
    if (first) begin
      jump       = 1'b0;
      run_next_s = {RUN_W{1'b0}};
    end else if (diff_s > DELTA_S) begin
      jump       = 1'b1;
      run_next_s = run_cnt + 3'd1;
    end else begin
      jump       = 1'b0;
      run_next_s = {RUN_W{1'b0}};
    end
    hit = eval && (run_next_s == CONFIRM_W);
  end

  // Consecutive-jump counter, advanced once per evaluated sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt <= {RUN_W{1'b0}};
    end else if (clear) begin
      run_cnt <= {RUN_W{1'b0}};
    end else if (eval) begin
      run_cnt <= run_next_s;
    end else begin
      run_cnt <= run_cnt;
    end
  end

endmodule

// File: rtl/instability_sweep.sv
// Sweeps a reference current downward from full scale, requesting one Q
// measurement per step, and looks for the point where Q starts jumping.
// When CONFIRM consecutive jumps are seen, the last reference that gave a
// stable sample becomes the Q-control upper bound (i_ref_setup).
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   start        - sweep request pulse (accepted only in IDLE with enable=1)
//   enable       - sweep permit; low aborts an active sweep without done
//   meas_start   - one-cycle measurement request
//   q_valid      - measurement-done strobe (only honoured while waiting)
//   q_measured   - measured Q
//   i_ref        - reference currently applied
//   i_ref_setup  - upper bound handed to the Q control module
//   busy         - sweep in progress (APPLY, WAIT, EVAL)
//   done         - one-cycle completion pulse
//   found        - instability located by the last sweep
//   timeout      - last sweep ended on a measurement timeout
module instability_sweep
  import instability_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int DELTA     = DELTA_DEF,
  parameter int IREF_STEP = IREF_STEP_DEF,
  parameter int IREF_MIN  = IREF_MIN_DEF,
  parameter int CONFIRM   = CONFIRM_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             enable,
  output logic             meas_start,
  input  logic             q_valid,
  input  logic [WIDTH-1:0] q_measured,
  output logic [WIDTH-1:0] i_ref,
  output logic [WIDTH-1:0] i_ref_setup,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             timeout
);

  localparam int               WAIT_W     = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] REF_MAX    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(IREF_STEP);
  // Stepping is allowed only while i_ref - IREF_STEP stays at or above IREF_MIN.
  localparam logic [WIDTH:0]   STEP_FLOOR = (WIDTH+1)'(IREF_MIN + IREF_STEP);

  state_t            state_r;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic [WIDTH-1:0]  q_lat_r;
  logic [WIDTH-1:0]  last_q_r;
  logic [WIDTH-1:0]  stable_r;
  logic              first_r;

  logic              clear_s;
  logic              eval_s;
  logic              jump_s;
  logic              hit_s;
  logic [RUN_W-1:0]  run_cnt_s;

  // Detector strobes: clear on an accepted start, classify in an enabled EVAL.
  always_comb begin
    clear_s = (state_r == ST_IDLE) && start && enable;
    eval_s  = (state_r == ST_EVAL) && enable;
  end

  jump_detector #(
    .WIDTH   (WIDTH),
    .DELTA   (DELTA),
    .CONFIRM (CONFIRM)
  ) u_jump_detector (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear_s),
    .eval    (eval_s),
    .first   (first_r),
    .q       (q_lat_r),
    .last_q  (last_q_r),
    .jump    (jump_s),
    .hit     (hit_s),
    .run_cnt (run_cnt_s)
  );

  // Sweep FSM; all outputs are registered and reflect the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      i_ref       <= REF_MAX;
      i_ref_setup <= REF_MAX;
      meas_start  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      found       <= 1'b0;
      timeout     <= 1'b0;
      wait_cnt_r  <= {WAIT_W{1'b0}};
      q_lat_r     <= {WIDTH{1'b0}};
      last_q_r    <= {WIDTH{1'b0}};
      stable_r    <= REF_MAX;
      first_r     <= 1'b0;
    end else begin
      meas_start <= 1'b0;
      done       <= 1'b0;
      if ((state_r != ST_IDLE) && !enable) begin
        // Abort: drop back without done; references keep their values.
        state_r <= ST_IDLE;
        busy    <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (start && enable) begin
              i_ref      <= REF_MAX;
              found      <= 1'b0;
              timeout    <= 1'b0;
              first_r    <= 1'b1;
              stable_r   <= REF_MAX;
              meas_start <= 1'b1;
              busy       <= 1'b1;
              state_r    <= ST_APPLY;
            end
          end
          ST_APPLY: begin
            wait_cnt_r <= {WAIT_W{1'b0}};
            state_r    <= ST_WAIT;
          end
          ST_WAIT: begin
            if (q_valid) begin
              q_lat_r <= q_measured;
              state_r <= ST_EVAL;
            end else if (wait_cnt_r == WAIT_LAST) begin
              timeout <= 1'b1;
              found   <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              state_r <= ST_FINISH;
            end else begin
              wait_cnt_r <= wait_cnt_r + 1'b1;
            end
          end
          ST_EVAL: begin
            last_q_r <= q_lat_r;
            first_r  <= 1'b0;
            // The last non-jumping reference is the candidate safe bound.
            if (!jump_s) begin
              stable_r <= i_ref;
            end
            if (hit_s) begin
              found       <= 1'b1;
              i_ref_setup <= stable_r;
              busy        <= 1'b0;
              done        <= 1'b1;
              state_r     <= ST_FINISH;
            end else if ({1'b0, i_ref} >= STEP_FLOOR) begin
              i_ref      <= i_ref - STEP_W;
              meas_start <= 1'b1;
              state_r    <= ST_APPLY;
            end else begin
              found   <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              state_r <= ST_FINISH;
            end
          end
          ST_FINISH: begin
            state_r <= ST_IDLE;
          end
          default: begin
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instability_sweep.sv
// Self-checking bench for instability_sweep: a Q responder answers each
// measurement request from a per-scenario Q profile, and the expected sweep
// outcome is queued at start and compared when done pulses.
module tb_instability_sweep;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         enable;
  logic         meas_start;
  logic         q_valid = 1'b0;
  logic [W-1:0] q_measured = '0;
  logic [W-1:0] i_ref;
  logic [W-1:0] i_ref_setup;
  logic         busy;
  logic         done;
  logic         found;
  logic         timeout;

  instability_sweep dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .enable      (enable),
    .meas_start  (meas_start),
    .q_valid     (q_valid),
    .q_measured  (q_measured),
    .i_ref       (i_ref),
    .i_ref_setup (i_ref_setup),
    .busy        (busy),
    .done        (done),
    .found       (found),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         f;
    logic         t;
    logic [W-1:0] s;
    logic [W-1:0] i;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int ms_cyc   = 0;
  int done_cyc = 0;
  int done_cnt = 0;

  // Scenario controls (written by the stimulus only).
  int mode          = 0;
  int withhold_from = 99;
  int sweep_id      = 0;
  // Responder state (written by the responder only).
  int seen_id       = 0;
  int sample_idx    = 0;
  int delay_cnt     = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Q profile per scenario, indexed by sample number within the sweep.
  function automatic logic [W-1:0] q_model(input int m, input int k);
    int v;
    case (m)
      0: v = (k < 3) ? 100 + 10 * k : ((k == 3) ? 520 : 870);  // +400 then +350
      1: v = (k < 3) ? 100 + 10 * k : 520;                      // single spike, flat
      2: v = (k == 0) ? 100 : ((k == 2) ? 200 : 700);           // jump, drop, jump, flat
      default: v = 100 + 10 * k;
    endcase
    return W'(v);
  endfunction

  always @(posedge clk) cyc++;

  // Measurement responder: answers two cycles after each request unless withheld.
  always @(negedge clk) begin
    if (seen_id != sweep_id) begin
      seen_id    = sweep_id;
      sample_idx = 0;
      delay_cnt  = 0;
    end
    q_valid = 1'b0;
    if (delay_cnt != 0) begin
      delay_cnt--;
      if (delay_cnt == 0) q_valid = 1'b1;
    end
    if (meas_start && !rst) begin
      check_val("step_iref", 32'(i_ref), 32'(1023 - 50 * sample_idx));
      ms_cyc     = cyc;
      q_measured = q_model(mode, sample_idx);
      if (sample_idx < withhold_from) delay_cnt = 2;
      sample_idx++;
    end
  end

  // Completion monitor: pops the scoreboard on every done cycle.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      check_val("busy_in_finish", 32'(busy), 32'd0);
      if (sb.size() == 0) begin
        check_val("done_unexpected", 32'(done), 32'd0);
      end else begin
        e = sb.pop_front();
        check_val("found", 32'(found), 32'(e.f));
        check_val("timeout", 32'(timeout), 32'(e.t));
        check_val("i_ref_setup", 32'(i_ref_setup), 32'(e.s));
        check_val("i_ref_final", 32'(i_ref), 32'(e.i));
      end
    end
  end

  task automatic begin_sweep(input int m, input int wfrom, input bit push,
                             input logic ef, input logic et,
                             input int es, input int ei);
    exp_t e;
    mode          = m;
    withhold_from = wfrom;
    sweep_id++;
    if (push) begin
      e.f = ef; e.t = et; e.s = W'(es); e.i = W'(ei);
      sb.push_back(e);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val("busy_apply", 32'(busy), 32'd1);
    check_val("meas_start_apply", 32'(meas_start), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      check_val("done_wait", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_idx(input int n, input int budget);
    int k = 0;
    while (sample_idx < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (sample_idx < n) check_val("sample_wait", 32'(sample_idx), 32'(n));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_i_ref"}, 32'(i_ref), 32'd1023);
    check_val({tag, "_setup"}, 32'(i_ref_setup), 32'd1023);
    check_val({tag, "_meas_start"}, 32'(meas_start), 32'd0);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_done"}, 32'(done), 32'd0);
    check_val({tag, "_found"}, 32'(found), 32'd0);
    check_val({tag, "_timeout"}, 32'(timeout), 32'd0);
  endtask

  initial begin
    int d0;
    int dt;
    rst    = 1'b1;
    enable = 1'b1;
    start  = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Ramp with +400 then +350: found, bound is last stable reference.
    // A start pulse mid-sweep must be ignored.
    d0 = done_cnt;
    begin_sweep(0, 99, 1'b1, 1'b1, 1'b0, 923, 823);
    wait_idx(2, 200);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(400);
    check_val("ramp_done_pulses", 32'(done_cnt - d0), 32'd1);
    check_val("ramp_found_hold", 32'(found), 32'd1);

    // Reset in the middle of a sweep: everything back to reset values, no done.
    begin_sweep(3, 2, 1'b0, 1'b0, 1'b0, 0, 0);
    wait_idx(3, 200);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    d0 = done_cnt;
    repeat (20) @(negedge clk);
    check_val("midrst_no_done", 32'(done_cnt - d0), 32'd0);

    // Single spike then flat: sweeps down to 23, nothing found.
    begin_sweep(1, 99, 1'b1, 1'b0, 1'b0, 1023, 23);
    wait_idle(800);

    // Jump, drop of -500, jump, flat: the drop clears the run, nothing found.
    begin_sweep(2, 99, 1'b1, 1'b0, 1'b0, 1023, 23);
    wait_idle(800);

    // enable low while waiting: abort next cycle, no done, references held.
    begin_sweep(3, 2, 1'b0, 1'b0, 1'b0, 0, 0);
    wait_idx(3, 200);
    repeat (5) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_i_ref", 32'(i_ref), 32'd923);
    check_val("abort_setup", 32'(i_ref_setup), 32'd1023);
    d0 = done_cnt;
    repeat (20) @(negedge clk);
    check_val("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check_val("abort_i_ref_held", 32'(i_ref), 32'd923);
    enable = 1'b1;
    @(negedge clk);

    // Measurement never arrives: timeout after about TIMEOUT cycles.
    begin_sweep(3, 0, 1'b1, 1'b0, 1'b1, 1023, 1023);
    wait_idle(1500);
    dt = done_cyc - ms_cyc;
    check_val("timeout_len_ok", 32'((dt >= 1023 && dt <= 1026) ? 1 : 0), 32'd1);
    check_val("timeout_hold", 32'(timeout), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
